tmr_error_monitor: RTL and testbench
====================================

TMR_ERROR_MONITOR -- requirements
Module: tmr_error_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the width of each replica word.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each per-replica error counter.
REQ-003 The block SHALL have parameter PERSIST, default 4, giving the consecutive-mismatch threshold that latches a replica fault; legal range is 1..15.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 port_sample_en  input  1  when high, the replica and voted inputs are valid this cycle.
REQ-007 port_rep_0, port_rep_1, port_rep_2  input  WIDTH each  triplicated register outputs.
REQ-008 port_voted  input  WIDTH  output of the downstream voter under observation.
REQ-009 port_clear  input  1  single-cycle pulse that clears counters, fault flags and state.
REQ-010 port_err_cnt_0, port_err_cnt_1, port_err_cnt_2  output  CNT_W each  saturating mismatch counts per replica.
REQ-011 port_fault  output  3  latched persistent-fault flag per replica; bit k maps to replica k.
REQ-012 port_voter_fault  output  1  latched flag: port_voted has disagreed with the internal majority.
REQ-013 port_state  output  2  encoding 00=OK, 01=DEGRADED, 10=FAILED; 11 is never driven.
REQ-014 port_err_pulse  output  1  one-cycle flag marking any mismatch on the previous sample.
REQ-015 port_alarm  output  1  high exactly while port_state=FAILED.

Function
REQ-016 The internal majority maj SHALL be the bitwise 2-of-3 vote of port_rep_0..2.
REQ-017 mis_k SHALL be 1 when port_rep_k != maj, compared as whole words.
REQ-018 A sample SHALL be word-uncorrectable when no two replicas are equal as whole words.
REQ-019 All evaluation SHALL occur only in cycles with port_sample_en=1; with port_sample_en=0 all state SHALL hold.
REQ-020 All outputs SHALL be registered; the effects of a sample SHALL appear on the cycle after it.
REQ-021 port_err_cnt_k SHALL increment by 1 on each sample with mis_k=1 and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-022 Each replica SHALL keep an internal consecutive-mismatch counter: +1 on a sample with mis_k=1, reset to 0 on a sample with mis_k=0, saturating at PERSIST.
REQ-023 port_fault[k] SHALL set in the same update in which consecutive counter k reaches PERSIST, and SHALL stay set until port_clear or reset.
REQ-024 port_voter_fault SHALL set on any sample where port_voted != maj and SHALL stay set until port_clear or reset.
REQ-025 port_err_pulse SHALL be 1 for exactly one cycle after any sample with any mis_k=1, any voter mismatch, or an uncorrectable word; otherwise it SHALL be 0.
REQ-026 State machine next state SHALL be computed from the updated flags:
- FAILED when two or more port_fault bits are set, port_voter_fault is set, or a word-uncorrectable sample occurs;
- else DEGRADED when exactly one port_fault bit is set;
- else OK.
REQ-027 FAILED SHALL be absorbing: only port_clear or reset leaves it.
REQ-028 port_clear=1 SHALL take priority over a simultaneous sample; next cycle all counters, flags and port_err_pulse SHALL be 0 and the state OK, and that sample SHALL be discarded.
REQ-029 Several replicas SHALL be allowed to mismatch on the same sample (possible when WIDTH>1), and each mismatching replica SHALL update independently.

Reset
REQ-030 With rst_n=0 at a rising clk edge, every output and internal counter SHALL be 0 and the state OK on the next cycle.
REQ-031 Reset SHALL override both port_clear and port_sample_en.
REQ-032 A reset asserted mid-accumulation SHALL discard all partial consecutive counts.

Verification
REQ-033 WIDTH=1: 3 samples rep=(1,1,1), voted=1 -> all counts 0, port_err_pulse never 1, state OK.
REQ-034 PERSIST=4: 4 consecutive samples rep=(0,1,1), voted=1 -> err_cnt_0=4, port_fault=001 and state DEGRADED after the 4th sample; err_pulse high after each sample.
REQ-035 Pattern mis_0 = 1,1,1,0,1,1,1 -> err_cnt_0=6, port_fault stays 000, state OK.
REQ-036 WIDTH=2: rep=(00,01,10) -> maj=00, word-uncorrectable, state FAILED, alarm=1; then a clean sample -> still FAILED; then port_clear -> OK, all counters 0.
REQ-037 rep=(1,1,1), voted=0 -> port_voter_fault=1 and FAILED; err_cnt_0=err_cnt_1=err_cnt_2=0.
REQ-038 CNT_W=2: 5 mismatches on replica 2 -> err_cnt_2 stays 3; port_clear coincident with a mismatching sample -> all counters 0 next cycle.

Source files
------------

// File: rtl/tmr_error_monitor.sv
// -----------------------------------------------------------------------------
// tmr_error_monitor
//
// Watches a triplicated register and the voter placed after it. On each valid
// sample it forms its own 2-of-3 majority and counts per-replica mismatches.
// A replica that disagrees on PERSIST samples in a row is latched as faulty.
// It also latches a fault when the external voter disagrees with the internal
// majority. A 3-state health FSM (OK / DEGRADED / FAILED) summarises the
// result. All outputs are registered, so a sample's effects appear one cycle
// later.
//
// Parameters
//   WIDTH    width of each replica word
//   CNT_W    width of each saturating per-replica error counter
//   PERSIST  consecutive-mismatch threshold that latches a fault (1..15)
//
// Ports
//   clk                 clock, rising edge
//   rst_n               synchronous active-low reset
//   port_sample_en      replica/voted inputs are valid this cycle
//   port_rep_0..2       replica words
//   port_voted          voter output under observation
//   port_clear          pulse: clear counters, flags and state (beats a sample)
//   port_err_cnt_0..2   saturating mismatch count per replica
//   port_fault          latched persistent-fault flag per replica
//   port_voter_fault    latched voter-disagreement flag
//   port_state          00=OK, 01=DEGRADED, 10=FAILED
//   port_err_pulse      one cycle after any sample that showed an error
//   port_alarm          high while port_state is FAILED
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_OK     | no latched faults
// ST_DEGR   | exactly one replica latched faulty; voting still correct
// ST_FAILED | >=2 faulty replicas, voter fault, or uncorrectable word seen;
//           | absorbing until port_clear or reset
// -----------------------------------------------------------------------------
module tmr_error_monitor #(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_sample_en,
  input  logic [WIDTH-1:0] port_rep_0,
  input  logic [WIDTH-1:0] port_rep_1,
  input  logic [WIDTH-1:0] port_rep_2,
  input  logic [WIDTH-1:0] port_voted,
  input  logic             port_clear,
  output logic [CNT_W-1:0] port_err_cnt_0,
  output logic [CNT_W-1:0] port_err_cnt_1,
  output logic [CNT_W-1:0] port_err_cnt_2,
  output logic [2:0]       port_fault,
  output logic             port_voter_fault,
  output logic [1:0]       port_state,
  output logic             port_err_pulse,
  output logic             port_alarm
);

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_DEGR   = 2'b01,
    ST_FAILED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       PERSIST_C = 4'(PERSIST);

  // Replica view and error classification
  logic [2:0][WIDTH-1:0] rep;
  logic [WIDTH-1:0]      maj;
  logic [2:0]            mis;
  logic                  uncorr;
  logic                  voter_mis;

  assign rep       = {port_rep_2, port_rep_1, port_rep_0};
  assign maj       = (port_rep_0 & port_rep_1) | (port_rep_1 & port_rep_2) |
                     (port_rep_0 & port_rep_2);
  assign uncorr    = (port_rep_0 != port_rep_1) && (port_rep_1 != port_rep_2) &&
                     (port_rep_0 != port_rep_2);
  assign voter_mis = (port_voted != maj);

  always_comb begin
    mis = '0;
    for (int k = 0; k < 3; k++) begin
      mis[k] = (rep[k] != maj);
    end
  end

  // Registers
  logic [2:0][CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0][3:0]       consec_q,  consec_d;
  logic [2:0]            fault_q,   fault_d;
  logic                  vfault_q,  vfault_d;
  logic                  pulse_q,   pulse_d;
  logic                  alarm_q,   alarm_d;
  state_t                state_q,   state_d;

  // Counters and latched flags
  always_comb begin
    err_cnt_d = err_cnt_q;
    consec_d  = consec_q;
    fault_d   = fault_q;
    vfault_d  = vfault_q;
    pulse_d   = 1'b0;
    if (port_clear) begin
      err_cnt_d = '0;
      consec_d  = '0;
      fault_d   = '0;
      vfault_d  = 1'b0;
    end else if (port_sample_en) begin
      for (int k = 0; k < 3; k++) begin
        if (mis[k]) begin
          if (err_cnt_q[k] != CNT_MAX) err_cnt_d[k] = err_cnt_q[k] + CNT_ONE;
          if (consec_q[k] != PERSIST_C) consec_d[k] = consec_q[k] + 4'd1;
        end else begin
          consec_d[k] = 4'd0;
        end
        // Latch on the very update that reaches the threshold.
        if (consec_d[k] == PERSIST_C) fault_d[k] = 1'b1;
      end
      vfault_d = vfault_q | voter_mis;
      pulse_d  = (|mis) | voter_mis | uncorr;
    end
  end

  // Health FSM, evaluated from the updated flags
  logic fault_multi;
  logic fault_single;

  assign fault_multi  = (fault_d[0] & fault_d[1]) | (fault_d[1] & fault_d[2]) |
                        (fault_d[0] & fault_d[2]);
  assign fault_single = (|fault_d) & ~fault_multi;

  always_comb begin
    state_d = state_q;
    if (port_clear) begin
      state_d = ST_OK;
    end else if (port_sample_en && (state_q != ST_FAILED)) begin
      if (fault_multi || vfault_d || uncorr) begin
        state_d = ST_FAILED;
      end else if (fault_single) begin
        state_d = ST_DEGR;
      end else begin
        state_d = ST_OK;
      end
    end
    alarm_d = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      consec_q  <= '0;
      fault_q   <= '0;
      vfault_q  <= 1'b0;
      pulse_q   <= 1'b0;
      alarm_q   <= 1'b0;
      state_q   <= ST_OK;
    end else begin
      err_cnt_q <= err_cnt_d;
      consec_q  <= consec_d;
      fault_q   <= fault_d;
      vfault_q  <= vfault_d;
      pulse_q   <= pulse_d;
      alarm_q   <= alarm_d;
      state_q   <= state_d;
    end
  end

  assign port_err_cnt_0   = err_cnt_q[0];
  assign port_err_cnt_1   = err_cnt_q[1];
  assign port_err_cnt_2   = err_cnt_q[2];
  assign port_fault       = fault_q;
  assign port_voter_fault = vfault_q;
  assign port_state       = state_q;
  assign port_err_pulse   = pulse_q;
  assign port_alarm       = alarm_q;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// -----------------------------------------------------------------------------
// Bench for tmr_error_monitor. Two instances share the same stimulus: a
// wide-counter one (CNT_W=8) and a narrow one (CNT_W=2) whose counters must
// saturate at 3. Each vector pushes its hand-computed expected outputs onto a
// queue. A separate monitor pops one entry per clock and compares both DUTs.
// -----------------------------------------------------------------------------
module tb_tmr_error_monitor;

  localparam logic [1:0] OK = 2'b00, DG = 2'b01, FL = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] rep_0 = '0, rep_1 = '0, rep_2 = '0, voted = '0;

  logic [7:0] a_c0, a_c1, a_c2;
  logic [1:0] b_c0, b_c1, b_c2;
  logic [2:0] a_fault, b_fault;
  logic       a_vf, b_vf, a_pulse, b_pulse, a_alarm, b_alarm;
  logic [1:0] a_state, b_state;

  tmr_error_monitor #(.WIDTH(2), .CNT_W(8), .PERSIST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .port_sample_en(sample_en),
    .port_rep_0(rep_0), .port_rep_1(rep_1), .port_rep_2(rep_2),
    .port_voted(voted), .port_clear(clear),
    .port_err_cnt_0(a_c0), .port_err_cnt_1(a_c1), .port_err_cnt_2(a_c2),
    .port_fault(a_fault), .port_voter_fault(a_vf), .port_state(a_state),
    .port_err_pulse(a_pulse), .port_alarm(a_alarm)
  );

  tmr_error_monitor #(.WIDTH(2), .CNT_W(2), .PERSIST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .port_sample_en(sample_en),
    .port_rep_0(rep_0), .port_rep_1(rep_1), .port_rep_2(rep_2),
    .port_voted(voted), .port_clear(clear),
    .port_err_cnt_0(b_c0), .port_err_cnt_1(b_c1), .port_err_cnt_2(b_c2),
    .port_fault(b_fault), .port_voter_fault(b_vf), .port_state(b_state),
    .port_err_pulse(b_pulse), .port_alarm(b_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c0, c1, c2;
    logic [2:0] fault;
    logic       vf;
    logic [1:0] st;
    logic       pulse;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;

  function automatic logic [1:0] sat3(input logic [7:0] x);
    return (x > 8'd3) ? 2'd3 : x[1:0];
  endfunction

  task automatic chk(input string name, input int id, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, name, act, exp);
    end
  endtask

  // Monitor: outputs of the vector driven before this edge are valid #1 after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      chk("a_cnt0",  mon_e.id, a_c0, mon_e.c0);
      chk("a_cnt1",  mon_e.id, a_c1, mon_e.c1);
      chk("a_cnt2",  mon_e.id, a_c2, mon_e.c2);
      chk("a_fault", mon_e.id, {5'd0, a_fault}, {5'd0, mon_e.fault});
      chk("a_vfault", mon_e.id, {7'd0, a_vf}, {7'd0, mon_e.vf});
      chk("a_state", mon_e.id, {6'd0, a_state}, {6'd0, mon_e.st});
      chk("a_pulse", mon_e.id, {7'd0, a_pulse}, {7'd0, mon_e.pulse});
      chk("a_alarm", mon_e.id, {7'd0, a_alarm}, {7'd0, (mon_e.st == FL)});
      chk("b_cnt0",  mon_e.id, {6'd0, b_c0}, {6'd0, sat3(mon_e.c0)});
      chk("b_cnt1",  mon_e.id, {6'd0, b_c1}, {6'd0, sat3(mon_e.c1)});
      chk("b_cnt2",  mon_e.id, {6'd0, b_c2}, {6'd0, sat3(mon_e.c2)});
      chk("b_fault", mon_e.id, {5'd0, b_fault}, {5'd0, mon_e.fault});
      chk("b_vfault", mon_e.id, {7'd0, b_vf}, {7'd0, mon_e.vf});
      chk("b_state", mon_e.id, {6'd0, b_state}, {6'd0, mon_e.st});
      chk("b_pulse", mon_e.id, {7'd0, b_pulse}, {7'd0, mon_e.pulse});
      chk("b_alarm", mon_e.id, {7'd0, b_alarm}, {7'd0, (mon_e.st == FL)});
    end
  end

  task automatic vec(input logic rst, input logic clr, input logic en,
                     input logic [1:0] r0, input logic [1:0] r1,
                     input logic [1:0] r2, input logic [1:0] v,
                     input logic [7:0] c0, input logic [7:0] c1,
                     input logic [7:0] c2, input logic [2:0] f,
                     input logic vf, input logic [1:0] st, input logic p);
    exp_t e;
    @(negedge clk);
    rst_n = rst; clear = clr; sample_en = en;
    rep_0 = r0; rep_1 = r1; rep_2 = r2; voted = v;
    e.c0 = c0; e.c1 = c1; e.c2 = c2; e.fault = f; e.vf = vf;
    e.st = st; e.pulse = p; e.id = n_push;
    n_push++;
    sb.push_back(e);
  endtask

  task automatic do_clear();
    vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, OK, 0);
  endtask

  initial begin
    // Reset state, and reset beating a simultaneous clear + mismatching sample
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, OK, 0);
    vec(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 3'b000, 0, OK, 0);

    // All replicas agree
    repeat (3) vec(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 3'b000, 0, OK, 0);
    // Mismatching inputs with sample_en low are ignored
    vec(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 3'b000, 0, OK, 0);

    // Replica 0 wrong four times in a row -> latched, DEGRADED on the 4th
    vec(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 2, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 3, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 4, 0, 0, 3'b001, 0, DG, 1);
    vec(1, 0, 0, 0, 1, 1, 1, 4, 0, 0, 3'b001, 0, DG, 0);
    do_clear();

    // mis_0 = 1,1,1,0,1,1,1: the gap restarts the run, no fault
    vec(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 2, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 3, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 1, 1, 1, 1, 3, 0, 0, 3'b000, 0, OK, 0);
    vec(1, 0, 1, 0, 1, 1, 1, 4, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 5, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 6, 0, 0, 3'b000, 0, OK, 1);
    // Fourth in the new run latches; fault stays latched when replica 1 errs
    vec(1, 0, 1, 0, 1, 1, 1, 7, 0, 0, 3'b001, 0, DG, 1);
    vec(1, 0, 1, 1, 0, 1, 1, 7, 1, 0, 3'b001, 0, DG, 1);
    do_clear();

    // Two replicas latched -> FAILED
    vec(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 2, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 3, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 4, 0, 0, 3'b001, 0, DG, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 4, 0, 1, 3'b001, 0, DG, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 4, 0, 2, 3'b001, 0, DG, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 4, 0, 3, 3'b001, 0, DG, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 4, 0, 4, 3'b101, 0, FL, 1);
    vec(1, 0, 1, 1, 1, 1, 1, 4, 0, 4, 3'b101, 0, FL, 0);
    do_clear();

    // Uncorrectable word (00,01,10): maj=00, replicas 1 and 2 both mismatch
    vec(1, 0, 1, 0, 1, 2, 0, 0, 1, 1, 3'b000, 0, FL, 1);
    vec(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0, FL, 0);
    do_clear();

    // Voter disagrees with a clean majority
    vec(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 3'b000, 1, FL, 1);
    vec(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 3'b000, 1, FL, 0);
    do_clear();

    // Five mismatches on replica 2 (narrow counter pins at 3)
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 2, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 3, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 4, 3'b100, 0, DG, 1);
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 5, 3'b100, 0, DG, 1);
    // Clear with a coincident mismatching sample discards the sample
    vec(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 3'b000, 0, OK, 0);
    vec(1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 3'b000, 0, OK, 1);
    do_clear();

    // Reset mid-run discards the partial consecutive count
    vec(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 2, 0, 0, 3'b000, 0, OK, 1);
    vec(1, 0, 1, 0, 1, 1, 1, 3, 0, 0, 3'b000, 0, OK, 1);
    vec(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 3'b000, 0, OK, 0);
    vec(1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 3'b000, 0, OK, 1);

    @(negedge clk);
    sample_en = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    if (n_vec != n_push) begin
      n_miss++;
      $display("FAIL count: %0d vectors checked, expected %0d", n_vec, n_push);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
